imm_gen_pipe: RTL and testbench

Pipelined, parametrised immediate generator for the SIMD decode stage. It accepts one instruction field set per valid/ready handshake and produces a DATA_W-bit immediate through an output FIFO, with one cycle of latency. Beyond zero-extension, it adds sign-extended immediates and a two-instruction long-immediate mode: a prefix opcode holds upper bits, and the next consuming instruction combines with them. It sits between instruction fetch/decode and the operand-select mux of the execute stage.

---
 rtl/imm_gen_pipe.sv | 217 +++++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator for the SIMD decode stage: decodes opcode/fields
// into a DATA_W-bit immediate (with optional long-immediate prefix) and queues it in an output FIFO.
module imm_gen_pipe #(
    parameter int DATA_W = 32,
    parameter int OPC_W  = 5,
    parameter int P1_W   = 5,
    parameter int P2_W   = 10,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [OPC_W-1:0]           in_op,
    input  logic [P1_W-1:0]            in_p1,
    input  logic [P2_W-1:0]            in_p2,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_imm,
    output logic [OPC_W-1:0]           out_op,
    output logic                       pfx_pending,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = P1_W + P2_W;
    localparam int LW = PW + P2_W;
    localparam int SW = PW + P1_W;

    localparam logic [OPC_W-1:0] OP_ZX2 = OPC_W'(5'b11000);
    localparam logic [OPC_W-1:0] OP_ZX1 = OPC_W'(5'b11001);
    localparam logic [OPC_W-1:0] OP_SX2 = OPC_W'(5'b11010);
    localparam logic [OPC_W-1:0] OP_PFX = OPC_W'(5'b11011);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PEND = 1'b1} state_t;

    function automatic logic [DATA_W-1:0] sext_long(input logic [LW-1:0] v);
        sext_long = DATA_W'($signed(v));
    endfunction

    function automatic logic [DATA_W-1:0] sext_short(input logic [P2_W-1:0] v);
        sext_short = DATA_W'($signed(v));
    endfunction

    state_t                  state_r, state_nxt_s;
    logic [PW-1:0]           pfx_r;
    logic [DATA_W-1:0]       mem_imm_r [DEPTH];
    logic [OPC_W-1:0]        mem_op_r  [DEPTH];
    logic [AW-1:0]           wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]           count_r;
    logic                    full_s, empty_s, accept_s, push_s, pop_s, pfx_load_s;
    logic [DATA_W-1:0]       imm_s;

    assign full_s   = (count_r == CW'(DEPTH));
    assign empty_s  = (count_r == {CW{1'b0}});
    assign in_ready = !full_s && !rst && !flush;
    assign accept_s = in_valid && in_ready;
    assign pop_s    = !empty_s && out_ready;

    // Opcode decode: builds the immediate and decides push versus prefix load.
    always_comb begin
        imm_s      = {DATA_W{1'b0}};
        push_s     = 1'b0;
        pfx_load_s = 1'b0;
        if (accept_s) begin
            case (in_op)
                OP_PFX: pfx_load_s = 1'b1;
                OP_ZX2: begin
                    push_s = 1'b1;
                    if (state_r == ST_PEND) begin
                        imm_s = DATA_W'({pfx_r, in_p2});
                    end else begin
                        imm_s = DATA_W'(in_p2);
                    end
                end
                OP_ZX1: begin
                    push_s = 1'b1;
                    if (state_r == ST_PEND) begin
                        imm_s = DATA_W'({pfx_r, in_p1});
                    end else begin
                        imm_s = DATA_W'(in_p1);
                    end
                end
                OP_SX2: begin
                    push_s = 1'b1;
                    if (state_r == ST_PEND) begin
                        imm_s = sext_long({pfx_r, in_p2});
                    end else begin
                        imm_s = sext_short(in_p2);
                    end
                end
                default: begin
                    push_s = 1'b1;
                    imm_s  = {DATA_W{1'b0}};
                end
            endcase
        end else begin
            imm_s      = {DATA_W{1'b0}};
            push_s     = 1'b0;
            pfx_load_s = 1'b0;
        end
    end

    // Prefix FSM state register; flush acts as the soft reset.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Prefix FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pfx_load_s) begin
                    state_nxt_s = ST_PEND;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (pfx_load_s) begin
                    state_nxt_s = ST_PEND;
                end else if (push_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_PEND;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Prefix FSM output decode.
    always_comb begin
        case (state_r)
            ST_PEND: pfx_pending = 1'b1;
            ST_IDLE: pfx_pending = 1'b0;
            default: pfx_pending = 1'b0;
        endcase
    end

    // Prefix register: loaded by PFX, dropped once any instruction consumes or discards it.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            pfx_r <= {PW{1'b0}};
        end else if (pfx_load_s) begin
            pfx_r <= {in_p1, in_p2};
        end else if (push_s) begin
            pfx_r <= {PW{1'b0}};
        end else begin
            pfx_r <= pfx_r;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_imm_r[i] <= {DATA_W{1'b0}};
                mem_op_r[i]  <= {OPC_W{1'b0}};
            end
        end else if (push_s) begin
            mem_imm_r[wr_ptr_r] <= imm_s;
            mem_op_r[wr_ptr_r]  <= in_op;
        end else begin
            mem_imm_r[wr_ptr_r] <= mem_imm_r[wr_ptr_r];
            mem_op_r[wr_ptr_r]  <= mem_op_r[wr_ptr_r];
        end
    end

    // Head-of-FIFO outputs, forced to zero when nothing is queued.
    always_comb begin
        if (empty_s) begin
            out_valid = 1'b0;
            out_imm   = {DATA_W{1'b0}};
            out_op    = {OPC_W{1'b0}};
        end else begin
            out_valid = 1'b1;
            out_imm   = mem_imm_r[rd_ptr_r];
            out_op    = mem_op_r[rd_ptr_r];
        end
    end

    assign count = count_r;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe with default parameters (DEPTH=2).
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, pfx_pending;
    logic [4:0]  in_op, in_p1, out_op;
    logic [9:0]  in_p2;
    logic [31:0] out_imm;
    logic [1:0]  count;
    int          tests_run = 0;
    int          tests_failed = 0;

    imm_gen_pipe dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_p1(in_p1), .in_p2(in_p2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_op(out_op),
        .pfx_pending(pfx_pending), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] op, input logic [4:0] p1, input logic [9:0] p2);
        in_valid = 1'b1; in_op = op; in_p1 = p1; in_p2 = p2;
        tick();
        in_valid = 1'b0; in_op = 5'd0; in_p1 = 5'd0; in_p2 = 10'd0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 5'd0; in_p1 = 5'd0; in_p2 = 10'd0;
        tick(); tick();
        // 1: reset state
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_imm", 64'(out_imm), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_pfx", 64'(pfx_pending), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // 2: zero-extension, back-to-back with simultaneous push/pop
        out_ready = 1'b1;
        send(5'b11000, 5'd0, 10'h3FF);
        chk("zx2_valid", 64'(out_valid), 64'd1);
        chk("zx2_imm", 64'(out_imm), 64'h0000_03FF);
        chk("zx2_op", 64'(out_op), 64'(5'b11000));
        send(5'b11001, 5'h15, 10'd0);
        chk("zx1_imm", 64'(out_imm), 64'h0000_0015);
        chk("zx1_op", 64'(out_op), 64'(5'b11001));
        chk("zx1_count", 64'(count), 64'd1);
        tick();
        chk("drain_valid", 64'(out_valid), 64'd0);
        chk("drain_imm", 64'(out_imm), 64'd0);

        // 3: short sign-extension
        send(5'b11010, 5'd0, 10'h200);
        chk("sx2_neg", 64'(out_imm), 64'hFFFF_FE00);
        send(5'b11010, 5'd0, 10'h1FF);
        chk("sx2_pos", 64'(out_imm), 64'h0000_01FF);
        tick();

        // 4: long immediates via prefix
        send(5'b11011, 5'h1F, 10'h3FF);
        chk("pfx_pending", 64'(pfx_pending), 64'd1);
        chk("pfx_no_out", 64'(out_valid), 64'd0);
        send(5'b11000, 5'd0, 10'h001);
        chk("long_zx2", 64'(out_imm), 64'h01FF_FC01);
        chk("long_zx2_pfx", 64'(pfx_pending), 64'd0);
        send(5'b11011, 5'h10, 10'h000);
        send(5'b11010, 5'd0, 10'h005);
        chk("long_sx2", 64'(out_imm), 64'hFF00_0005);
        tick();
        // non-consuming opcode in PEND discards the prefix and pushes zero
        send(5'b11011, 5'h01, 10'h001);
        send(5'b00011, 5'h1F, 10'h3FF);
        chk("other_imm", 64'(out_imm), 64'd0);
        chk("other_op", 64'(out_op), 64'(5'b00011));
        chk("other_pfx", 64'(pfx_pending), 64'd0);
        send(5'b11001, 5'h07, 10'd0);
        chk("after_discard", 64'(out_imm), 64'h0000_0007);
        tick();

        // 5: backpressure with full FIFO
        out_ready = 1'b0;
        send(5'b11001, 5'h01, 10'd0);
        send(5'b11001, 5'h02, 10'd0);
        chk("full_count", 64'(count), 64'd2);
        in_valid = 1'b1; in_op = 5'b11001; in_p1 = 5'h03; in_p2 = 10'd0;
        #1;
        chk("full_in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("full_hold_imm", 64'(out_imm), 64'h0000_0001);
        chk("full_hold_count", 64'(count), 64'd2);
        out_ready = 1'b1;
        #1;
        chk("full_pop_in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("pop_count", 64'(count), 64'd1);
        chk("pop_head", 64'(out_imm), 64'h0000_0002);
        out_ready = 1'b0;
        #1;
        chk("space_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("third_count", 64'(count), 64'd2);
        chk("third_head", 64'(out_imm), 64'h0000_0002);
        out_ready = 1'b1;
        tick();
        chk("order_third", 64'(out_imm), 64'h0000_0003);
        tick();
        chk("order_empty", 64'(count), 64'd0);

        // 6: flush with prefix pending and a queued entry
        out_ready = 1'b0;
        send(5'b11000, 5'd0, 10'h007);
        send(5'b11011, 5'h01, 10'h001);
        chk("pre_flush_count", 64'(count), 64'd1);
        chk("pre_flush_pfx", 64'(pfx_pending), 64'd1);
        flush = 1'b1; in_valid = 1'b1; in_op = 5'b11000; in_p2 = 10'h009;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_pfx", 64'(pfx_pending), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        send(5'b11000, 5'd0, 10'h001);
        chk("post_flush_imm", 64'(out_imm), 64'h0000_0001);
        chk("post_flush_count", 64'(count), 64'd1);

        // reset while a prefix is pending
        send(5'b11011, 5'h1F, 10'h3FF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_pfx", 64'(pfx_pending), 64'd0);
        chk("midrst_count", 64'(count), 64'd0);
        send(5'b11000, 5'd0, 10'h002);
        chk("midrst_imm", 64'(out_imm), 64'h0000_0002);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
